// File: rtl/gray_step_counter.sv
// Up/down Gray-code step counter with synchronous load and count enable.
// The binary count is the true state; gray, wrap and flip are registered beside it.
module gray_step_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pulse,
  input  logic         enable,
  input  logic         up_down,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray,
  output logic [N-1:0] bin,
  output logic         wrap,
  output logic [N-1:0] flip
);

  logic [N-1:0] bin_q,  bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic [N-1:0] flip_q, flip_d;
  logic         wrap_q, wrap_d;

  logic         stepEn;
  logic [N-1:0] stepBin;
  logic         stepWrap;

  assign stepEn = pulse & enable;

  always_comb begin
    stepBin  = bin_q;
    stepWrap = 1'b0;
    if (up_down) begin
      stepBin  = bin_q + N'(1);
      stepWrap = (bin_q == {N{1'b1}});
    end else begin
      stepBin  = bin_q - N'(1);
      stepWrap = (bin_q == {N{1'b0}});
    end
  end

  // Priority is load > step > hold; reset is applied in the register block.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    flip_d = '0;
    if (load) begin
      bin_d  = load_val;
      gray_d = load_val ^ (load_val >> 1);
    end else if (stepEn) begin
      bin_d  = stepBin;
      gray_d = stepBin ^ (stepBin >> 1);
      wrap_d = stepWrap;
      flip_d = gray_q ^ (stepBin ^ (stepBin >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      flip_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      flip_q <= flip_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;
  assign flip = flip_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// Scoreboard bench for gray_step_counter: a driver pushes model predictions,
// a monitor pops one per clock after the edge and compares against the DUT.
module tb_gray_step_counter;

  localparam int N    = 4;
  localparam int SIZE = 1 << N;

  typedef struct {
    int    gray;
    int    bin;
    int    wrap;
    int    flip;
    string tag;
  } expect_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pulse = 1'b0;
  logic         enable = 1'b0;
  logic         up_down = 1'b1;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] gray, bin, flip;
  logic         wrap;

  expect_t expQ[$];
  int      grayTab[SIZE];
  int      mCount = 0;
  int      vectors = 0;
  int      miscompares = 0;
  bit      driverDone = 1'b0;

  gray_step_counter #(.N(N)) dut (
    .clk(clk), .reset(reset), .pulse(pulse), .enable(enable),
    .up_down(up_down), .load(load), .load_val(load_val),
    .gray(gray), .bin(bin), .wrap(wrap), .flip(flip)
  );

  always #5 clk = ~clk;

  // Reflected-binary table built by mirroring, independent of the xor formula.
  initial begin
    int len;
    grayTab[0] = 0;
    len = 1;
    for (int b = 0; b < N; b++) begin
      for (int i = 0; i < len; i++) grayTab[len + i] = grayTab[len - 1 - i] | (1 << b);
      len = len * 2;
    end
  end

  task automatic applyStimulus(input bit r, input bit p, input bit en, input bit ud,
                               input bit ld, input int lv, input string tag);
    expect_t e;
    int      old;
    int      w, f;
    @(negedge clk);
    reset = r; pulse = p; enable = en; up_down = ud; load = ld; load_val = N'(lv);
    w = 0; f = 0;
    if (!r) begin
      mCount = 0;
    end else if (ld) begin
      mCount = lv % SIZE;
    end else if (p && en) begin
      old = mCount;
      if (ud) begin
        mCount = old + 1;
        if (mCount == SIZE) begin w = 1; mCount = 0; end
      end else begin
        mCount = old - 1;
        if (mCount < 0) begin w = 1; mCount = SIZE - 1; end
      end
      f = grayTab[old] ^ grayTab[mCount];
    end
    e.gray = grayTab[mCount]; e.bin = mCount; e.wrap = w; e.flip = f; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    vectors++;
    if (int'(gray) != e.gray || int'(bin) != e.bin || int'(wrap) != e.wrap || int'(flip) != e.flip) begin
      miscompares++;
      $display("[TB] FAIL %s: got gray=%h bin=%h wrap=%b flip=%h, expected gray=%h bin=%h wrap=%0d flip=%h",
               e.tag, gray, bin, wrap, flip, e.gray[N-1:0], e.bin[N-1:0], e.wrap, e.flip[N-1:0]);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    int lv;
    applyStimulus(0, 0, 0, 1, 0, 0, "reset");
    applyStimulus(0, 1, 1, 1, 0, 0, "reset_hold");
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 1, 1, 0, 0, "count_up");
    applyStimulus(1, 0, 1, 0, 1, 'hA, "load_A");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0, "count_down");
    applyStimulus(1, 0, 1, 0, 1, 0, "load_0");
    applyStimulus(1, 1, 1, 0, 0, 0, "down_wrap");
    applyStimulus(1, 0, 1, 0, 0, 0, "after_wrap_idle");
    applyStimulus(1, 1, 1, 1, 1, 5, "load_beats_pulse");
    applyStimulus(1, 0, 1, 1, 1, 3, "load_3");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1, 0, 0, "enable_low");
    applyStimulus(1, 1, 1, 1, 0, 0, "enable_step");
    applyStimulus(1, 0, 1, 1, 1, 'hF, "load_F");
    applyStimulus(0, 1, 1, 1, 0, 0, "reset_beats_pulse");
    applyStimulus(1, 0, 1, 1, 0, 0, "post_reset_idle");
    applyStimulus(1, 0, 1, 0, 1, 0, "load_0_rev");
    applyStimulus(1, 1, 1, 0, 0, 0, "reverse_down_wrap");
    applyStimulus(1, 1, 1, 1, 0, 0, "reverse_up_wrap");
    for (int i = 0; i < 400; i++) begin
      lv = int'($urandom_range(0, SIZE - 1));
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 9) == 0, lv, "random");
    end
    repeat (3) @(negedge clk);
    driverDone = 1'b1;
  end

  initial begin : finisher
    fork
      wait (driverDone);
      #100000;
    join_any
    disable fork;
    if (!driverDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: pending=%0d done=%0b, required pending=0 done=1", expQ.size(), driverDone);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
